decode_stage: RTL and testbench

- Instruction-decode pipeline stage between instruction fetch and the immediate extender / execute stage.
- Accepts 32-bit instructions from fetch through a valid/ready handshake and buffers them in a 2-entry skid buffer.
- Splits each instruction into register fields, the raw 26-bit immediate field and the ImmSrc select, and presents them with a registered valid/ready handshake.
- The imm and ImmSrc outputs drive the immediate extender directly.

---
 rtl/decode_pkg.sv | 43 ++++
 rtl/instr_fields_decode.sv | 36 +++
 rtl/decode_stage.sv | 125 ++++++++++++
 tb/tb_decode_stage.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared types and constants for the instruction-decode stage.
// The top module's optional Illegal output is enabled by the macro DECODE_ILLEGAL_TRAP_EN.
package decode_pkg;

  localparam int INSTR_W = 32;
  localparam int OPC_W   = 6;
  localparam int IMM_W   = 26;

  // Field bit positions; the fields overlap on purpose.
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RD_HI  = 25;
  localparam int RN_HI  = 21;
  localparam int RM_HI  = 17;
  localparam int IMM_HI = 25;
  localparam int IMM_LO = 0;

  localparam logic [1:0] IMM13 = 2'b00;
  localparam logic [1:0] IMM17 = 2'b01;
  localparam logic [1:0] IMM26 = 2'b10;

  typedef enum logic [1:0] {
    CLS_ALU = 2'b00,
    CLS_MEM = 2'b01,
    CLS_BR  = 2'b10,
    CLS_SYS = 2'b11
  } instr_class_e;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } buf_state_e;

  function automatic logic [1:0] class_imm_src(input instr_class_e cls);
    case (cls)
      CLS_ALU: class_imm_src = IMM13;
      CLS_MEM: class_imm_src = IMM17;
      default: class_imm_src = IMM26;
    endcase
  endfunction

endpackage

// File: rtl/instr_fields_decode.sv
// Purely combinational split of an instruction word into fields and ImmSrc.
// The illegal output exists only when DECODE_ILLEGAL_TRAP_EN is defined.
module instr_fields_decode
  import decode_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [OPC_W-1:0]   opcode,
  output logic [REG_AW-1:0]  rd,
  output logic [REG_AW-1:0]  rn,
  output logic [REG_AW-1:0]  rm,
  output logic [IMM_W-1:0]   imm,
  output logic [1:0]         imm_src
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic               illegal
`endif
);

  instr_class_e cls;

  assign opcode  = instr[OPC_HI:OPC_LO];
  assign rd      = instr[RD_HI -: REG_AW];
  assign rn      = instr[RN_HI -: REG_AW];
  assign rm      = instr[RM_HI -: REG_AW];
  assign imm     = instr[IMM_HI:IMM_LO];
  assign cls     = instr_class_e'(opcode[5:4]);
  assign imm_src = class_imm_src(cls);

`ifdef DECODE_ILLEGAL_TRAP_EN
  // Only 0x30..0x33 are defined in the system class.
  assign illegal = (cls == CLS_SYS) && (opcode[3:0] > 4'h3);
`endif

endmodule

// File: rtl/decode_stage.sv
// Decode stage: 2-entry skid buffer (main/skid) feeding a combinational field decoder.
// Optional Illegal output enabled by DECODE_ILLEGAL_TRAP_EN.
module decode_stage
  import decode_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int PC_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                InValid,
  output logic                InReady,
  input  logic [INSTR_W-1:0]  InInstr,
  input  logic [PC_W-1:0]     InPC,
  input  logic                Flush,
  output logic                OutValid,
  input  logic                OutReady,
  output logic [PC_W-1:0]     OutPC,
  output logic [OPC_W-1:0]    Opcode,
  output logic [REG_AW-1:0]   Rd,
  output logic [REG_AW-1:0]   Rn,
  output logic [REG_AW-1:0]   Rm,
  output logic [IMM_W-1:0]    imm,
  output logic [1:0]          ImmSrc
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic                Illegal
`endif
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               valid;
  } buf_entry_t;

  buf_state_e state;
  buf_entry_t main_e, skid_e, in_e;
  logic       in_xfer, out_xfer;

  assign InReady  = (state != FULL);
  assign OutValid = main_e.valid;
  assign in_xfer  = InValid && InReady;
  assign out_xfer = OutValid && OutReady;
  assign in_e     = '{instr: InInstr, pc: InPC, valid: 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_e <= '0;
      skid_e <= '0;
    end else if (Flush) begin
      state  <= EMPTY;
      main_e <= '0;
      skid_e <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_e <= in_e;
            state  <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_e <= in_e;
          end else if (in_xfer) begin
            skid_e <= in_e;
            state  <= FULL;
          end else if (out_xfer) begin
            main_e <= '0;
            state  <= EMPTY;
          end
        end
        FULL: begin
          // No input is accepted here, so the skid simply drains into main.
          if (out_xfer) begin
            main_e <= skid_e;
            skid_e <= '0;
            state  <= ONE;
          end
        end
        default: begin
          state  <= EMPTY;
          main_e <= '0;
          skid_e <= '0;
        end
      endcase
    end
  end

  logic [OPC_W-1:0]  dec_opcode;
  logic [REG_AW-1:0] dec_rd, dec_rn, dec_rm;
  logic [IMM_W-1:0]  dec_imm;
  logic [1:0]        dec_imm_src;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic              dec_illegal;
`endif

  instr_fields_decode #(.REG_AW(REG_AW)) u_fields (
    .instr   (main_e.instr),
    .opcode  (dec_opcode),
    .rd      (dec_rd),
    .rn      (dec_rn),
    .rm      (dec_rm),
    .imm     (dec_imm),
    .imm_src (dec_imm_src)
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    .illegal (dec_illegal)
`endif
  );

  assign OutPC  = main_e.valid ? main_e.pc   : '0;
  assign Opcode = main_e.valid ? dec_opcode  : '0;
  assign Rd     = main_e.valid ? dec_rd      : '0;
  assign Rn     = main_e.valid ? dec_rn      : '0;
  assign Rm     = main_e.valid ? dec_rm      : '0;
  assign imm    = main_e.valid ? dec_imm     : '0;
  assign ImmSrc = main_e.valid ? dec_imm_src : '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign Illegal = main_e.valid && dec_illegal;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: scoreboard of accepted instructions checked in order at the output.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [31:0] InInstr = '0;
  logic [31:0] InPC = '0;
  logic        Flush = 1'b0;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic [31:0] OutPC;
  logic [5:0]  Opcode;
  logic [3:0]  Rd, Rn, Rm;
  logic [25:0] imm;
  logic [1:0]  ImmSrc;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic        Illegal;
`endif

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  decode_stage #(.REG_AW(4), .PC_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .InValid  (InValid),
    .InReady  (InReady),
    .InInstr  (InInstr),
    .InPC     (InPC),
    .Flush    (Flush),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .OutPC    (OutPC),
    .Opcode   (Opcode),
    .Rd       (Rd),
    .Rn       (Rn),
    .Rm       (Rm),
    .imm      (imm),
    .ImmSrc   (ImmSrc)
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    .Illegal  (Illegal)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] model_imm_src(input logic [5:0] op);
    if (op[5:4] == 2'b00) return 2'b00;
    if (op[5:4] == 2'b01) return 2'b01;
    return 2'b10;
  endfunction

  // Output monitor: pops the oldest accepted instruction on each output transfer.
  always @(negedge clk) begin
    if (rst || Flush) begin
      sb.delete();
    end else begin
      if (OutValid && OutReady) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL sb_underflow: output pc=%h with no expected entry", OutPC);
        end else begin
          exp_t e;
          logic [5:0] op;
          e = sb.pop_front();
          op = e.instr[31:26];
          if (OutPC !== e.pc || Opcode !== op || Rd !== e.instr[25:22] ||
              Rn !== e.instr[21:18] || Rm !== e.instr[17:14] ||
              imm !== e.instr[25:0] || ImmSrc !== model_imm_src(op)) begin
            miscompares++;
            $display("FAIL sb_fields: got pc=%h op=%h rd=%h rn=%h rm=%h imm=%h src=%b, want pc=%h op=%h rd=%h rn=%h rm=%h imm=%h src=%b",
                     OutPC, Opcode, Rd, Rn, Rm, imm, ImmSrc, e.pc, op, e.instr[25:22],
                     e.instr[21:18], e.instr[17:14], e.instr[25:0], model_imm_src(op));
          end
`ifdef DECODE_ILLEGAL_TRAP_EN
          if (Illegal !== (op[5:4] == 2'b11 && op[3:0] > 4'h3)) begin
            miscompares++;
            $display("FAIL sb_illegal: got %b for op %h", Illegal, op);
          end
`endif
        end
      end
      if (!OutValid) begin
        vectors++;
        if (OutPC !== '0 || Opcode !== '0 || Rd !== '0 || Rn !== '0 || Rm !== '0 ||
            imm !== '0 || ImmSrc !== '0) begin
          miscompares++;
          $display("FAIL idle_zero: got pc=%h op=%h imm=%h src=%b, want all 0", OutPC, Opcode, imm, ImmSrc);
        end
      end
      if (InValid && InReady) sb.push_back('{pc: InPC, instr: InInstr});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    InValid = 1'b1;
    InInstr = instr;
    InPC    = pc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (OutValid !== 1'b0 || InReady !== 1'b1 || OutPC !== '0 || Opcode !== '0 ||
        imm !== '0 || ImmSrc !== '0) begin
      miscompares++;
      $display("FAIL reset: got valid=%b ready=%b pc=%h op=%h imm=%h src=%b, want 0 1 0 0 0 0",
               OutValid, InReady, OutPC, Opcode, imm, ImmSrc);
    end
  endtask

  task automatic test_single();
    OutReady = 1'b1;
    offer(32'h1C84_0005, 32'h0000_0100);
    tick();
    InValid = 1'b0;
    vectors++;
    if (OutValid !== 1'b1 || ImmSrc !== 2'b00 || Rd !== 4'd2 || Rn !== 4'd1 ||
        Rm !== 4'd0 || imm !== 26'h084_0005 || Opcode !== 6'h07 || OutPC !== 32'h100) begin
      miscompares++;
      $display("FAIL single: got valid=%b src=%b rd=%h rn=%h rm=%h imm=%h op=%h pc=%h, want 1 00 2 1 0 0840005 07 100",
               OutValid, ImmSrc, Rd, Rn, Rm, imm, Opcode, OutPC);
    end
    tick();
    vectors++;
    if (OutValid !== 1'b0 || InReady !== 1'b1) begin
      miscompares++;
      $display("FAIL single_drain: got valid=%b ready=%b, want 0 1", OutValid, InReady);
    end
  endtask

  task automatic test_backpressure();
    OutReady = 1'b0;
    offer(32'h4A00_1234, 32'h200);
    tick();
    offer(32'h88C0_0042, 32'h204);
    tick();
    offer(32'h0D55_AAAA, 32'h208);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (InReady !== 1'b0 || OutValid !== 1'b1 || OutPC !== 32'h200 ||
          Opcode !== 6'h12 || imm !== 26'h200_1234 || ImmSrc !== 2'b01) begin
        miscompares++;
        $display("FAIL bp_hold: cycle %0d got ready=%b valid=%b pc=%h op=%h imm=%h src=%b, want 0 1 200 12 2001234 01",
                 i, InReady, OutValid, OutPC, Opcode, imm, ImmSrc);
      end
    end
    OutReady = 1'b1;
    tick();
    vectors++;
    if (InReady !== 1'b1 || OutPC !== 32'h204) begin
      miscompares++;
      $display("FAIL bp_release: got ready=%b pc=%h, want 1 204", InReady, OutPC);
    end
    tick();
    InValid = 1'b0;
    vectors++;
    if (OutPC !== 32'h208) begin
      miscompares++;
      $display("FAIL bp_third: got pc=%h, want 208", OutPC);
    end
    tick();
  endtask

  task automatic test_streaming();
    OutReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer({$urandom_range(63, 0) % 64 == 0 ? 6'h01 : 6'($urandom), 26'($urandom)},
            32'h1000 + 32'(i * 4));
      tick();
      vectors++;
      if (OutValid !== 1'b1 || OutPC !== 32'h1000 + 32'(i * 4)) begin
        miscompares++;
        $display("FAIL stream: step %0d got valid=%b pc=%h, want 1 %h", i, OutValid, OutPC,
                 32'h1000 + 32'(i * 4));
      end
    end
    InValid = 1'b0;
    tick();
    vectors++;
    if (OutValid !== 1'b0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL stream_end: got valid=%b pending=%0d, want 0 0", OutValid, sb.size());
    end
  endtask

  task automatic test_flush();
    OutReady = 1'b0;
    offer(32'h0440_0001, 32'h300);
    tick();
    offer(32'h0880_0002, 32'h304);
    tick();
    vectors++;
    if (InReady !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_full: got ready=%b, want 0", InReady);
    end
    offer(32'h0CC0_0003, 32'h308);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    InValid = 1'b0;
    vectors++;
    if (OutValid !== 1'b0 || InReady !== 1'b1 || OutPC !== '0 || Opcode !== '0) begin
      miscompares++;
      $display("FAIL flush: got valid=%b ready=%b pc=%h op=%h, want 0 1 0 0", OutValid, InReady, OutPC, Opcode);
    end
    OutReady = 1'b1;
    tick();
    vectors++;
    if (OutValid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_lost: got valid=%b, want 0", OutValid);
    end
  endtask

  task automatic test_class();
    logic [31:0] instrs [5];
    logic [1:0]  src_exp [5];
    logic [25:0] imm_exp [5];
    logic        ill_exp [5];
    instrs[0] = {6'h10, 26'h000_1111}; src_exp[0] = 2'b01; imm_exp[0] = 26'h000_1111; ill_exp[0] = 1'b0;
    instrs[1] = {6'h25, 26'h3FF_FFFF}; src_exp[1] = 2'b10; imm_exp[1] = 26'h3FF_FFFF; ill_exp[1] = 1'b0;
    instrs[2] = {6'h31, 26'h000_0000}; src_exp[2] = 2'b10; imm_exp[2] = 26'h000_0000; ill_exp[2] = 1'b0;
    instrs[3] = {6'h3A, 26'h012_3456}; src_exp[3] = 2'b10; imm_exp[3] = 26'h012_3456; ill_exp[3] = 1'b1;
    instrs[4] = {6'h33, 26'h155_5555}; src_exp[4] = 2'b10; imm_exp[4] = 26'h155_5555; ill_exp[4] = 1'b0;
    OutReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      offer(instrs[i], 32'h400 + 32'(i * 4));
      tick();
      InValid = 1'b0;
      vectors++;
      if (ImmSrc !== src_exp[i] || imm !== imm_exp[i]) begin
        miscompares++;
        $display("FAIL class_%0d: got src=%b imm=%h, want %b %h", i, ImmSrc, imm, src_exp[i], imm_exp[i]);
      end
`ifdef DECODE_ILLEGAL_TRAP_EN
      vectors++;
      if (Illegal !== ill_exp[i]) begin
        miscompares++;
        $display("FAIL illegal_%0d: got %b, want %b", i, Illegal, ill_exp[i]);
      end
`endif
      tick();
    end
  endtask

  task automatic test_reset_midstall();
    OutReady = 1'b0;
    offer(32'h1111_1111, 32'h500);
    tick();
    offer(32'h2222_2222, 32'h504);
    tick();
    offer(32'h3333_3333, 32'h508);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    InValid = 1'b0;
    vectors++;
    if (OutValid !== 1'b0 || InReady !== 1'b1 || OutPC !== '0 || Opcode !== '0 || Rd !== '0 ||
        Rn !== '0 || Rm !== '0 || imm !== '0 || ImmSrc !== '0) begin
      miscompares++;
      $display("FAIL reset_stall: got valid=%b ready=%b pc=%h op=%h imm=%h src=%b, want 0 1 0 0 0 0",
               OutValid, InReady, OutPC, Opcode, imm, ImmSrc);
    end
    OutReady = 1'b1;
    tick();
    vectors++;
    if (OutValid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stall_empty: got valid=%b, want 0", OutValid);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_single();
    test_backpressure();
    test_streaming();
    test_flush();
    test_class();
    test_reset_midstall();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
